led_ws2812_tx: RTL and testbench
================================

// Module: led_ws2812_tx
// PURPOSE
//   Reader end of the LED backlight path: pulls 24-bit GRB zone values from the prefetch
//   FIFO (rd_en/rd_vld/rd_data side) and serialises them onto a WS2812-style one-wire LED chain.
//   Sits after the local-dimming zone calculator and the FIFO, in the FIFO read clock domain.
//   One frame = N_LEDS words, followed by a latch (reset-low) period.
// PARAMETERS
//   N_LEDS        64     words (LEDs) per frame, 1..4095
//   T0H           20     clk cycles high for a '0' bit (0.4 us @ 50 MHz)
//   T1H           40     clk cycles high for a '1' bit (0.8 us @ 50 MHz)
//   TBIT          63     clk cycles per bit period, TBIT > T1H > T0H > 0
//   RESET_CYCLES  15000  clk cycles of low line after the last bit (300 us @ 50 MHz)
// PORTS
//   clk           in   1   single clock (FIFO read clock)
//   rst           in   1   synchronous, active-high reset
//   start         in   1   1-cycle pulse: begin one frame; ignored while busy
//   busy          out  1   high from the cycle after accepted start until done
//   done          out  1   1-cycle pulse at end of latch period
//   underrun      out  1   sticky: FIFO was empty when a word was needed; cleared on accepted start
//   fifo_rd_en    out  1   pop strobe to prefetch FIFO
//   fifo_rd_vld   in   1   FIFO head word valid (first-word-fall-through)
//   fifo_rd_data  in   24  FIFO head word, {G[7:0],R[7:0],B[7:0]}, sent MSB first
//   led_dout      out  1   serial LED data line, registered
// BEHAVIOUR
//   Reset: state IDLE; busy=0, done=0, underrun=0, fifo_rd_en=0, led_dout=0; counters 0.
//   Reset mid-frame returns to IDLE immediately, no done, FIFO not flushed (owner flushes).
//   States: IDLE -> FETCH -> BIT -> (FETCH | LATCH) -> IDLE.
//   IDLE : led_dout=0. start=1 -> FETCH, pix_cnt<=0, underrun<=0.
//   FETCH: fifo_rd_en = (state==FETCH) & fifo_rd_vld (combinational; exactly one pop per word).
//          Pop cycle: shreg<=fifo_rd_data, bit_cnt<=23, tick<=0 -> BIT.
//          fifo_rd_vld=0: stay, line held low, underrun<=1 (frame resumes when data arrives).
//   BIT  : tick counts 0..TBIT-1; led_dout(next) = (tick < (shreg[23] ? T1H : T0H)).
//          tick==TBIT-1: if bit_cnt!=0 -> shreg<<=1, bit_cnt--, tick<=0, stay in BIT;
//          else if pix_cnt==N_LEDS-1 -> LATCH, lat_cnt<=0; else pix_cnt++ -> FETCH.
//   LATCH: led_dout=0 for RESET_CYCLES cycles; at lat_cnt==RESET_CYCLES-1 pulse done, -> IDLE.
//   Timing: led_dout rises 1 cycle after entering BIT (register stage). Bit period is exactly
//     TBIT within a word; last bit of each non-final word gets TBIT+1 (+ any FIFO-wait cycles)
//     because of the FETCH cycle, extending only its low phase.
//   Start-to-first-rise latency with FIFO non-empty: 3 cycles (IDLE->FETCH->BIT->dout).
//   busy = (state != IDLE), registered with state. start while busy: no effect, no extra pop.
//   Counters: tick 7b, bit_cnt 5b, pix_cnt 12b, lat_cnt 16b; no wrap occurs within legal params.
//   FIFO-empty gap longer than ~50 us latches the chain early; underrun flags it for software.
// TESTING
//   1 N_LEDS=2, FIFO holds 24'hFF0000, 24'h00000F; start -> 2 fifo_rd_en pulses; line shows
//     8 pulses of 40 high then 16 of 20 high, then 20x20, 4x40; low 15000; done 1 cycle; busy=0.
//   2 Bit timing: rising-edge spacing 63 cycles inside a word, 64 at word boundary; '1' high=40,
//     '0' high=20 measured cycle-exact.
//   3 FIFO empty at start, fifo_rd_vld rises 100 cycles later -> led_dout low, underrun=1 from
//     first FETCH cycle, frame then completes normally; next start clears underrun.
//   4 start re-pulsed mid-frame and during LATCH -> ignored: pop count stays N_LEDS, one done.
//   5 rst asserted at bit 10 of word 1 -> next cycle state IDLE, led_dout=0, busy=0, no done;
//     fresh start afterwards sends a full frame from the next FIFO word.
//   6 Back-to-back: start on the cycle after done -> accepted, second frame identical to first.

Source files
------------

// File: rtl/led_ws2812_tx_if.sv
// Prefetch FIFO read port (first-word-fall-through) as seen by the WS2812 serialiser.
interface led_ws2812_tx_if;
    logic        fifo_rd_en;
    logic        fifo_rd_vld;
    logic [23:0] fifo_rd_data;

    modport master (output fifo_rd_en, input fifo_rd_vld, input fifo_rd_data);
    modport slave  (input fifo_rd_en, output fifo_rd_vld, output fifo_rd_data);
endinterface

// File: rtl/led_ws2812_tx.sv
// WS2812 one-wire serialiser: pops N_LEDS GRB words from the prefetch FIFO per frame,
// sends each MSB first as fixed-period high/low pulses, then holds the line low to latch.
module led_ws2812_tx #(
    parameter int N_LEDS       = 64,
    parameter int T0H          = 20,
    parameter int T1H          = 40,
    parameter int TBIT         = 63,
    parameter int RESET_CYCLES = 15000
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    output logic underrun,
    output logic led_dout,
    led_ws2812_tx_if.master fifo_if
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_BIT, S_LATCH} state_t;

    localparam logic [6:0]  TICK_LAST = 7'(TBIT - 1);
    localparam logic [6:0]  T0H_C     = 7'(T0H);
    localparam logic [6:0]  T1H_C     = 7'(T1H);
    localparam logic [11:0] PIX_LAST  = 12'(N_LEDS - 1);
    localparam logic [15:0] LAT_LAST  = 16'(RESET_CYCLES - 1);

    state_t      state, state_nxt;
    logic [6:0]  tick;
    logic [4:0]  bit_cnt;
    logic [11:0] pix_cnt;
    logic [15:0] lat_cnt;
    logic [23:0] shreg;
    logic        pop;
    logic        tick_end;

    assign tick_end           = (tick == TICK_LAST);
    assign fifo_if.fifo_rd_en = pop;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            S_IDLE:  if (start) state_nxt = S_FETCH;
            S_FETCH: if (fifo_if.fifo_rd_vld) begin
                pop       = 1'b1;
                state_nxt = S_BIT;
            end
            S_BIT:   if (tick_end && bit_cnt == 5'd0)
                state_nxt = (pix_cnt == PIX_LAST) ? S_LATCH : S_FETCH;
            S_LATCH: if (lat_cnt == LAT_LAST) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            underrun <= 1'b0;
            led_dout <= 1'b0;
            tick     <= '0;
            bit_cnt  <= '0;
            pix_cnt  <= '0;
            lat_cnt  <= '0;
            shreg    <= '0;
        end else begin
            busy     <= (state_nxt != S_IDLE);
            done     <= (state == S_LATCH) && (lat_cnt == LAT_LAST);
            // Line level is decided from the current tick, so it lags state by one cycle.
            led_dout <= (state == S_BIT) && (tick < (shreg[23] ? T1H_C : T0H_C));
            case (state)
                S_IDLE: if (start) begin
                    pix_cnt  <= '0;
                    underrun <= 1'b0;
                end
                S_FETCH: begin
                    if (pop) begin
                        shreg   <= fifo_if.fifo_rd_data;
                        bit_cnt <= 5'd23;
                        tick    <= '0;
                    end else begin
                        underrun <= 1'b1;
                    end
                end
                S_BIT: begin
                    if (!tick_end) begin
                        tick <= tick + 7'd1;
                    end else if (bit_cnt != 5'd0) begin
                        shreg   <= {shreg[22:0], 1'b0};
                        bit_cnt <= bit_cnt - 5'd1;
                        tick    <= '0;
                    end else if (pix_cnt == PIX_LAST) begin
                        lat_cnt <= '0;
                    end else begin
                        pix_cnt <= pix_cnt + 12'd1;
                    end
                end
                S_LATCH: lat_cnt <= lat_cnt + 16'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_led_ws2812_tx.sv
// Bench for led_ws2812_tx: FIFO model plus line monitor; expected pulse widths are queued
// when words are pushed and compared against measured widths after each frame.
module tb_led_ws2812_tx;
    localparam int N_LEDS       = 2;
    localparam int T0H          = 20;
    localparam int T1H          = 40;
    localparam int TBIT         = 63;
    localparam int RESET_CYCLES = 1500;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;
    logic busy, done, underrun, led_dout;

    led_ws2812_tx_if fif();

    led_ws2812_tx #(
        .N_LEDS(N_LEDS), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .RESET_CYCLES(RESET_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .underrun(underrun), .led_dout(led_dout), .fifo_if(fif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // FIFO model: writes from the stimulus process, pops from the clocked process.
    logic [23:0] fifo_mem [0:63];
    int   fifo_wp = 0;
    int   fifo_rp = 0;
    logic hold    = 1'b0;
    int   cyc     = 0;

    assign fif.fifo_rd_vld  = !hold && (fifo_rp != fifo_wp);
    assign fif.fifo_rd_data = fifo_mem[fifo_rp[5:0]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fif.fifo_rd_en) fifo_rp <= fifo_rp + 1;
    end

    // Line monitor, sampled mid-cycle.
    logic prev_dout = 1'b0;
    int   rise_t = 0, fall_t = 0, done_t = 0;
    int   rise_cnt = 0, done_cnt = 0, pops = 0;
    int   width_q [$];
    int   rise_q  [$];

    always @(negedge clk) begin
        if (led_dout && !prev_dout) begin
            rise_t   <= cyc;
            rise_q.push_back(cyc);
            rise_cnt <= rise_cnt + 1;
        end
        if (!led_dout && prev_dout) begin
            width_q.push_back(cyc - rise_t);
            fall_t <= cyc;
        end
        if (fif.fifo_rd_en) pops <= pops + 1;
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_t   <= cyc;
        end
        prev_dout <= led_dout;
    end

    int exp_w [$];

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic push_word(input logic [23:0] w);
        fifo_mem[fifo_wp[5:0]] = w;
        fifo_wp = fifo_wp + 1;
        for (int b = 23; b >= 0; b--) exp_w.push_back(w[b] ? T1H : T0H);
    endtask

    task automatic pulse_start(output int t);
        start = 1'b1;
        t = cyc;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        int n0;
        n0 = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            tick(1);
            if (done_cnt != n0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_rises(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (rise_cnt >= target) begin ok = 1'b1; break; end
            tick(1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b want 0", underrun); end
        checks++; if (fif.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b want 0", fif.fifo_rd_en); end
        checks++; if (led_dout !== 1'b0) begin errors++; $display("FAIL reset_dout got %b want 0", led_dout); end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_frame_basic();
        int w0, p0, d0, st;
        bit ok;
        exp_w.delete();
        w0 = width_q.size(); p0 = pops; d0 = done_cnt;
        push_word(24'hFF0000);
        push_word(24'h00000F);
        pulse_start(st);
        tick(1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy); end
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_done_timeout got 0 want 1"); end
        checks++; if (pops - p0 != N_LEDS) begin errors++; $display("FAIL basic_pops got %0d want %0d", pops - p0, N_LEDS); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done_cnt got %0d want 1", done_cnt - d0); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width got %b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end got %b want 0", busy); end
        checks++;
        if (done_t - fall_t != TBIT - T1H - 1 + RESET_CYCLES) begin
            errors++; $display("FAIL basic_latch_low got %0d want %0d", done_t - fall_t, TBIT - T1H - 1 + RESET_CYCLES);
        end
        checks++;
        if (width_q.size() - w0 != exp_w.size()) begin
            errors++; $display("FAIL basic_pulse_count got %0d want %0d", width_q.size() - w0, exp_w.size());
        end
        for (int i = 0; i < exp_w.size(); i++) begin
            checks++;
            if (w0 + i >= width_q.size()) begin errors++; $display("FAIL basic_width[%0d] got none want %0d", i, exp_w[i]); end
            else if (width_q[w0 + i] != exp_w[i]) begin
                errors++; $display("FAIL basic_width[%0d] got %0d want %0d", i, width_q[w0 + i], exp_w[i]);
            end
        end
    endtask

    task automatic test_bit_timing();
        int w0, r0, st, want;
        bit ok;
        exp_w.delete();
        w0 = width_q.size(); r0 = rise_q.size();
        push_word(24'($urandom));
        push_word(24'($urandom));
        pulse_start(st);
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL timing_done_timeout got 0 want 1"); end
        checks++;
        if (rise_q.size() - r0 != 48) begin
            errors++; $display("FAIL timing_rise_count got %0d want 48", rise_q.size() - r0);
        end else begin
            checks++;
            if (rise_q[r0] - st != 3) begin errors++; $display("FAIL timing_latency got %0d want 3", rise_q[r0] - st); end
            for (int i = 0; i < 47; i++) begin
                want = (i == 23) ? TBIT + 1 : TBIT;
                checks++;
                if (rise_q[r0 + i + 1] - rise_q[r0 + i] != want) begin
                    errors++; $display("FAIL timing_spacing[%0d] got %0d want %0d", i, rise_q[r0 + i + 1] - rise_q[r0 + i], want);
                end
            end
        end
        for (int i = 0; i < exp_w.size(); i++) begin
            checks++;
            if (w0 + i >= width_q.size()) begin errors++; $display("FAIL timing_width[%0d] got none want %0d", i, exp_w[i]); end
            else if (width_q[w0 + i] != exp_w[i]) begin
                errors++; $display("FAIL timing_width[%0d] got %0d want %0d", i, width_q[w0 + i], exp_w[i]);
            end
        end
    endtask

    task automatic test_underrun();
        int w0, p0, st;
        bit ok;
        exp_w.delete();
        w0 = width_q.size(); p0 = pops;
        hold = 1'b1;
        push_word(24'hA5C30F);
        push_word(24'h3C0081);
        pulse_start(st);
        tick(1);
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL under_first_fetch got %b want 1", underrun); end
        tick(99);
        checks++; if (led_dout !== 1'b0) begin errors++; $display("FAIL under_dout got %b want 0", led_dout); end
        checks++; if (pops != p0) begin errors++; $display("FAIL under_pops got %0d want %0d", pops - p0, 0); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL under_busy got %b want 1", busy); end
        hold = 1'b0;
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL under_done_timeout got 0 want 1"); end
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL under_sticky got %b want 1", underrun); end
        for (int i = 0; i < exp_w.size(); i++) begin
            checks++;
            if (w0 + i >= width_q.size()) begin errors++; $display("FAIL under_width[%0d] got none want %0d", i, exp_w[i]); end
            else if (width_q[w0 + i] != exp_w[i]) begin
                errors++; $display("FAIL under_width[%0d] got %0d want %0d", i, width_q[w0 + i], exp_w[i]);
            end
        end
        push_word(24'h010203);
        push_word(24'h040506);
        pulse_start(st);
        tick(2);
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL under_clear got %b want 0", underrun); end
        wait_done(ok);
        checks++; if (!ok || underrun !== 1'b0) begin errors++; $display("FAIL under_clean_frame got %b want 0", underrun); end
    endtask

    task automatic test_start_ignored();
        int w0, p0, d0, r0, st, dummy;
        bit ok;
        exp_w.delete();
        w0 = width_q.size(); p0 = pops; d0 = done_cnt; r0 = rise_cnt;
        push_word(24'h123456);
        push_word(24'h89ABCD);
        pulse_start(st);
        wait_rises(r0 + 30, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ign_rise_timeout got 0 want 1"); end
        pulse_start(dummy);
        wait_rises(r0 + 48, ok);
        tick(TBIT + 50);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ign_latch_busy got %b want 1", busy); end
        pulse_start(dummy);
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL ign_done_timeout got 0 want 1"); end
        tick(200);
        checks++; if (pops - p0 != N_LEDS) begin errors++; $display("FAIL ign_pops got %0d want %0d", pops - p0, N_LEDS); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL ign_done_cnt got %0d want 1", done_cnt - d0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_busy_after got %b want 0", busy); end
        for (int i = 0; i < exp_w.size(); i++) begin
            checks++;
            if (w0 + i >= width_q.size()) begin errors++; $display("FAIL ign_width[%0d] got none want %0d", i, exp_w[i]); end
            else if (width_q[w0 + i] != exp_w[i]) begin
                errors++; $display("FAIL ign_width[%0d] got %0d want %0d", i, width_q[w0 + i], exp_w[i]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int w0, p0, d0, r0, st;
        bit ok;
        r0 = rise_cnt; p0 = pops; d0 = done_cnt;
        push_word(24'hFFFFFF);
        push_word(24'h000000);
        pulse_start(st);
        wait_rises(r0 + 35, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_rise_timeout got 0 want 1"); end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
        checks++; if (led_dout !== 1'b0) begin errors++; $display("FAIL rstmid_dout got %b want 0", led_dout); end
        tick(RESET_CYCLES + 200);
        checks++; if (done_cnt != d0) begin errors++; $display("FAIL rstmid_no_done got %0d want %0d", done_cnt, d0); end
        checks++; if (pops - p0 != 2) begin errors++; $display("FAIL rstmid_pops got %0d want 2", pops - p0); end
        exp_w.delete();
        w0 = width_q.size(); p0 = pops;
        push_word(24'h5A5AA5);
        push_word(24'hC0FFEE);
        pulse_start(st);
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_done_timeout got 0 want 1"); end
        checks++; if (pops - p0 != N_LEDS) begin errors++; $display("FAIL rstmid_refill_pops got %0d want %0d", pops - p0, N_LEDS); end
        for (int i = 0; i < exp_w.size(); i++) begin
            checks++;
            if (w0 + i >= width_q.size()) begin errors++; $display("FAIL rstmid_width[%0d] got none want %0d", i, exp_w[i]); end
            else if (width_q[w0 + i] != exp_w[i]) begin
                errors++; $display("FAIL rstmid_width[%0d] got %0d want %0d", i, width_q[w0 + i], exp_w[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int w0, p0, d0, r0, st1, st2;
        bit ok1, ok2;
        exp_w.delete();
        w0 = width_q.size(); p0 = pops; d0 = done_cnt; r0 = rise_q.size();
        push_word(24'h80FF01);
        push_word(24'h7E0055);
        push_word(24'h80FF01);
        push_word(24'h7E0055);
        pulse_start(st1);
        wait_done(ok1);
        pulse_start(st2);
        wait_done(ok2);
        checks++; if (!ok1 || !ok2) begin errors++; $display("FAIL b2b_done_timeout got %b%b want 11", ok1, ok2); end
        checks++; if (done_cnt - d0 != 2) begin errors++; $display("FAIL b2b_done_cnt got %0d want 2", done_cnt - d0); end
        checks++; if (pops - p0 != 2 * N_LEDS) begin errors++; $display("FAIL b2b_pops got %0d want %0d", pops - p0, 2 * N_LEDS); end
        checks++;
        if (rise_q.size() - r0 != 96) begin
            errors++; $display("FAIL b2b_rise_count got %0d want 96", rise_q.size() - r0);
        end else begin
            checks++;
            if (rise_q[r0 + 48] - st2 != 3) begin errors++; $display("FAIL b2b_latency2 got %0d want 3", rise_q[r0 + 48] - st2); end
            for (int i = 0; i < 47; i++) begin
                checks++;
                if (rise_q[r0 + 49 + i] - rise_q[r0 + 48 + i] != rise_q[r0 + 1 + i] - rise_q[r0 + i]) begin
                    errors++; $display("FAIL b2b_spacing[%0d] got %0d want %0d", i,
                        rise_q[r0 + 49 + i] - rise_q[r0 + 48 + i], rise_q[r0 + 1 + i] - rise_q[r0 + i]);
                end
            end
        end
        for (int i = 0; i < exp_w.size(); i++) begin
            checks++;
            if (w0 + i >= width_q.size()) begin errors++; $display("FAIL b2b_width[%0d] got none want %0d", i, exp_w[i]); end
            else if (width_q[w0 + i] != exp_w[i]) begin
                errors++; $display("FAIL b2b_width[%0d] got %0d want %0d", i, width_q[w0 + i], exp_w[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame_basic();
        test_bit_timing();
        test_underrun();
        test_start_ignored();
        test_reset_midframe();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
